// File: rtl/osc_ctrl_pkg.sv
// osc_ctrl_pkg: shared types and constants for the ring-oscillator controller.
//   osc_state_t : controller FSM states (OFF, INJECT, RUN, SLEW)
//   LFSR_SEED   : reset seed of the optional dither LFSR
//   LFSR_TAPS   : feedback tap mask (x^16 + x^14 + x^13 + x^11)
//   therm_enc() : binary count -> thermometer code (low 'count' bits set)
// The dither LFSR is only built when OSC_PERB_DITHER_EN is defined.
package osc_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        INJECT = 2'd1,
        RUN    = 2'd2,
        SLEW   = 2'd3
    } osc_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps at bit positions 16,14,13,11 (1-based) -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned THERM_MAX_W = 32;

    // Callers size-cast the result down to their MSB width.
    function automatic logic [THERM_MAX_W-1:0] therm_enc(input int unsigned count);
        logic [THERM_MAX_W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < THERM_MAX_W; i++) begin
            t[i] = (i < count);
        end
        return t;
    endfunction

endpackage

// File: rtl/osc_msb_slewer.sv
// osc_msb_slewer: walks one stage's MSB count toward a target, one step every
// SLEW_DIV cycles while active.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : latch cur_i / tgt_i and restart the divider
//   cur_i, tgt_i : starting count and target count
//   active_i     : slewing enabled this cycle
//   count_o      : count after the step being taken
//   step_o       : a step is taken at this edge
//   last_o       : the step taken at this edge reaches the target
//   done_o       : current count equals target
module osc_msb_slewer #(
    parameter int unsigned MSB_CW   = 4,
    parameter int unsigned SLEW_DIV = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [MSB_CW-1:0] cur_i,
    input  logic [MSB_CW-1:0] tgt_i,
    input  logic              active_i,
    output logic [MSB_CW-1:0] count_o,
    output logic              step_o,
    output logic              last_o,
    output logic              done_o
);

    localparam int unsigned DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

    logic [DIV_W-1:0]  div_q;
    logic [MSB_CW-1:0] cur_q, tgt_q;
    logic              tick;

    assign tick    = active_i && (div_q == DIV_W'(SLEW_DIV - 1));
    assign count_o = (cur_q < tgt_q) ? cur_q + 1'b1 : cur_q - 1'b1;
    assign step_o  = tick && (cur_q != tgt_q);
    assign last_o  = step_o && (count_o == tgt_q);
    assign done_o  = (cur_q == tgt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            cur_q <= '0;
            tgt_q <= '0;
        end else if (load_i) begin
            div_q <= '0;
            cur_q <= cur_i;
            tgt_q <= tgt_i;
        end else if (active_i) begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (step_o) begin
                cur_q <= count_o;
            end
        end
    end

endmodule

// File: rtl/osc_ring_ctrl.sv
// osc_ring_ctrl: start-up sequencer and per-stage delay-code store for an
// N_STAGE ring oscillator. Run-time MSB changes are slewed one step at a time.
//   ref_clk, rst        : sole clock, synchronous active-high reset
//   start               : level request for the oscillator to run
//   wr_valid/wr_ready   : code-write handshake (wr_stage, wr_lsb, wr_msb, wr_perb)
//   glob_en, inj_en     : ring enable, edge-injector enable
//   delay_con_lsb/_msb  : per-stage binary LSB / thermometer MSB codes (stage i at slice i)
//   con_perb            : per-stage perturbation codes
//   busy, locked        : slew in progress / running with no slew pending
// Optional: define OSC_PERB_DITHER_EN to XOR an LFSR dither onto con_perb.
module osc_ring_ctrl
    import osc_ctrl_pkg::*;
#(
    parameter int unsigned N_STAGE  = 5,
    parameter int unsigned LSB_W    = 5,
    parameter int unsigned MSB_W    = 8,
    parameter int unsigned PERB_W   = 4,
    parameter int unsigned INJ_CYC  = 16,
    parameter int unsigned SLEW_DIV = 4
) (
    input  logic                        ref_clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(N_STAGE)-1:0]  wr_stage,
    input  logic [LSB_W-1:0]            wr_lsb,
    input  logic [$clog2(MSB_W+1)-1:0]  wr_msb,
    input  logic [PERB_W-1:0]           wr_perb,
    output logic                        glob_en,
    output logic                        inj_en,
    output logic [N_STAGE*LSB_W-1:0]    delay_con_lsb,
    output logic [N_STAGE*MSB_W-1:0]    delay_con_msb,
    output logic [N_STAGE*PERB_W-1:0]   con_perb,
    output logic                        busy,
    output logic                        locked
);

    localparam int unsigned STG_W  = $clog2(N_STAGE);
    localparam int unsigned MSB_CW = $clog2(MSB_W + 1);
    localparam int unsigned INJ_W  = (INJ_CYC > 1) ? $clog2(INJ_CYC) : 1;

    osc_state_t         state_q, state_d;
    logic [INJ_W-1:0]   inj_cnt_q, inj_cnt_d;
    logic [LSB_W-1:0]   lsb_q [N_STAGE];
    logic [LSB_W-1:0]   lsb_d [N_STAGE];
    logic [MSB_CW-1:0]  msb_q [N_STAGE];
    logic [MSB_CW-1:0]  msb_d [N_STAGE];
    logic [PERB_W-1:0]  perb_q [N_STAGE];
    logic [PERB_W-1:0]  perb_d [N_STAGE];
    logic [STG_W-1:0]   slw_stage_q, slw_stage_d;
    logic [LSB_W-1:0]   slw_lsb_q, slw_lsb_d;

    logic               wr_fire, stage_ok, slew_req, slw_load;
    logic [STG_W-1:0]   idx;
    logic [MSB_CW-1:0]  msb_clamp;
    logic [MSB_CW-1:0]  sl_count;
    logic               sl_step, sl_last, sl_done;

    assign wr_ready  = (state_q != SLEW);
    assign wr_fire   = wr_valid && wr_ready;
    assign stage_ok  = (32'(wr_stage) < N_STAGE);
    assign idx       = stage_ok ? wr_stage : '0;
    assign msb_clamp = (wr_msb > MSB_CW'(MSB_W)) ? MSB_CW'(MSB_W) : wr_msb;
    // Only a running ring that stays running needs a gradual MSB change.
    assign slew_req  = wr_fire && stage_ok && (state_q == RUN) && start &&
                       (msb_clamp != msb_q[idx]);

    osc_msb_slewer #(
        .MSB_CW   (MSB_CW),
        .SLEW_DIV (SLEW_DIV)
    ) u_slewer (
        .clk_i    (ref_clk),
        .rst_i    (rst),
        .load_i   (slw_load),
        .cur_i    (msb_q[idx]),
        .tgt_i    (msb_clamp),
        .active_i ((state_q == SLEW) && start),
        .count_o  (sl_count),
        .step_o   (sl_step),
        .last_o   (sl_last),
        .done_o   (sl_done)
    );

    always_comb begin
        state_d     = state_q;
        inj_cnt_d   = inj_cnt_q;
        lsb_d       = lsb_q;
        msb_d       = msb_q;
        perb_d      = perb_q;
        slw_stage_d = slw_stage_q;
        slw_lsb_d   = slw_lsb_q;
        slw_load    = 1'b0;

        case (state_q)
            OFF: begin
                if (start) begin
                    state_d   = INJECT;
                    inj_cnt_d = '0;
                end
            end
            INJECT: begin
                if (!start) begin
                    state_d = OFF;
                end else if (inj_cnt_q == INJ_W'(INJ_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    inj_cnt_d = inj_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = OFF;
                end else if (slew_req) begin
                    state_d = SLEW;
                end
            end
            SLEW: begin
                // Dropping start abandons the target; codes stay where they are.
                if (!start) begin
                    state_d = OFF;
                end else if (sl_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = OFF;
        endcase

        if (wr_fire && stage_ok) begin
            perb_d[idx] = wr_perb;
            if (slew_req) begin
                slw_stage_d = idx;
                slw_lsb_d   = wr_lsb;
                slw_load    = 1'b1;
            end else begin
                lsb_d[idx] = wr_lsb;
                msb_d[idx] = msb_clamp;
            end
        end

        // No write can be accepted in SLEW, so these never collide with the above.
        if (sl_step) begin
            msb_d[slw_stage_q] = sl_count;
            if (sl_last) begin
                lsb_d[slw_stage_q] = slw_lsb_q;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q     <= OFF;
            inj_cnt_q   <= '0;
            slw_stage_q <= '0;
            slw_lsb_q   <= '0;
            for (int i = 0; i < int'(N_STAGE); i++) begin
                lsb_q[i]  <= '0;
                msb_q[i]  <= MSB_CW'(MSB_W / 2);
                perb_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            inj_cnt_q   <= inj_cnt_d;
            slw_stage_q <= slw_stage_d;
            slw_lsb_q   <= slw_lsb_d;
            lsb_q       <= lsb_d;
            msb_q       <= msb_d;
            perb_q      <= perb_d;
        end
    end

    assign glob_en = (state_q != OFF);
    assign inj_en  = (state_q == INJECT);
    assign busy    = (state_q == SLEW);
    assign locked  = (state_q == RUN);

`ifdef OSC_PERB_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        dith_on;

    assign dith_on = (state_q == RUN) || (state_q == SLEW);

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == RUN) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    for (genvar i = 0; i < int'(N_STAGE); i++) begin : g_out
        assign delay_con_lsb[i*LSB_W +: LSB_W] = lsb_q[i];
        assign delay_con_msb[i*MSB_W +: MSB_W] = MSB_W'(therm_enc(32'(msb_q[i])));
`ifdef OSC_PERB_DITHER_EN
        // Stage i sees the dither rotated left by i so stages decorrelate.
        localparam int unsigned ROT = i % PERB_W;
        logic [PERB_W-1:0] rot;
        assign rot = (lfsr_q[PERB_W-1:0] << ROT) | (lfsr_q[PERB_W-1:0] >> (PERB_W - ROT));
        assign con_perb[i*PERB_W +: PERB_W] = dith_on ? (perb_q[i] ^ rot) : perb_q[i];
`else
        assign con_perb[i*PERB_W +: PERB_W] = perb_q[i];
`endif
    end

endmodule

// File: tb/tb_osc_ring_ctrl.sv
// tb_osc_ring_ctrl: scripted + randomized stimulus; a cycle-level behavioural
// model pushes expected outputs into a queue, a negedge monitor pops and compares.
module tb_osc_ring_ctrl;

    localparam int N = 5, LW = 5, MW = 8, PW = 4, INJ = 16, SDIV = 4;
    localparam int SW = $clog2(N), MCW = $clog2(MW + 1);
    localparam int S_OFF = 0, S_INJ = 1, S_RUN = 2, S_SLEW = 3;

    logic ref_clk = 1'b0, rst = 1'b1, start = 1'b0, wr_valid = 1'b0;
    logic wr_ready, glob_en, inj_en, busy, locked;
    logic [SW-1:0]  wr_stage = '0;
    logic [LW-1:0]  wr_lsb = '0;
    logic [MCW-1:0] wr_msb = '0;
    logic [PW-1:0]  wr_perb = '0;
    logic [N*LW-1:0] delay_con_lsb;
    logic [N*MW-1:0] delay_con_msb;
    logic [N*PW-1:0] con_perb;

    osc_ring_ctrl u_dut (
        .ref_clk(ref_clk), .rst(rst), .start(start), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_stage(wr_stage), .wr_lsb(wr_lsb), .wr_msb(wr_msb),
        .wr_perb(wr_perb), .glob_en(glob_en), .inj_en(inj_en),
        .delay_con_lsb(delay_con_lsb), .delay_con_msb(delay_con_msb),
        .con_perb(con_perb), .busy(busy), .locked(locked)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct packed {
        logic glob, inj, busy, locked, rdy;
        logic [N*LW-1:0] lsb;
        logic [N*MW-1:0] msb;
        logic [N*PW-1:0] perb;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, failures = 0, cyc = 0;

    // Reference model state
    int m_state, m_inj;
    int m_lsb[N], m_msb[N], m_perb[N];
    int s_stage, s_from, s_to, s_lsb, s_t;
    logic [15:0] m_lfsr;

    function automatic void model_reset();
        m_state = S_OFF; m_inj = 0;
        for (int i = 0; i < N; i++) begin
            m_lsb[i] = 0; m_msb[i] = MW / 2; m_perb[i] = 0;
        end
        m_lfsr = 16'hACE1;
    endfunction

    function automatic void model_step();
        int ns, cm, st, d, dir;
        if (rst) begin
            model_reset();
            return;
        end
        ns = m_state;
        if (m_state == S_RUN)
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        case (m_state)
            S_OFF: if (start) begin ns = S_INJ; m_inj = 0; end
            S_INJ: begin
                if (!start) ns = S_OFF;
                else begin
                    m_inj++;
                    if (m_inj == INJ) ns = S_RUN;
                end
            end
            S_RUN: if (!start) ns = S_OFF;
            default: begin
                if (!start) ns = S_OFF;
                else begin
                    s_t++;
                    dir = (s_to > s_from) ? 1 : -1;
                    d = (s_to > s_from) ? s_to - s_from : s_from - s_to;
                    if (s_t <= d * SDIV) m_msb[s_stage] = s_from + dir * (s_t / SDIV);
                    if (s_t == d * SDIV) m_lsb[s_stage] = s_lsb;
                    if (s_t == d * SDIV + 1) ns = S_RUN;
                end
            end
        endcase
        if (wr_valid && m_state != S_SLEW && int'(wr_stage) < N) begin
            st = int'(wr_stage);
            cm = (int'(wr_msb) > MW) ? MW : int'(wr_msb);
            m_perb[st] = int'(wr_perb);
            if (m_state == S_RUN && start && cm != m_msb[st]) begin
                s_stage = st; s_from = m_msb[st]; s_to = cm; s_lsb = int'(wr_lsb); s_t = 0;
                ns = S_SLEW;
            end else begin
                m_lsb[st] = int'(wr_lsb);
                m_msb[st] = cm;
            end
        end
        m_state = ns;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [PW-1:0] x, rot;
        e.glob   = (m_state != S_OFF);
        e.inj    = (m_state == S_INJ);
        e.busy   = (m_state == S_SLEW);
        e.locked = (m_state == S_RUN);
        e.rdy    = (m_state != S_SLEW);
        for (int i = 0; i < N; i++) begin
            e.lsb[i*LW +: LW]  = LW'(m_lsb[i]);
            e.msb[i*MW +: MW]  = MW'((64'd1 << m_msb[i]) - 64'd1);
            e.perb[i*PW +: PW] = PW'(m_perb[i]);
`ifdef OSC_PERB_DITHER_EN
            if (m_state == S_RUN || m_state == S_SLEW) begin
                x = m_lfsr[PW-1:0];
                for (int j = 0; j < PW; j++) rot[(j + i) % PW] = x[j];
                e.perb[i*PW +: PW] = PW'(m_perb[i]) ^ rot;
            end
`else
            x = '0; rot = x;
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge ref_clk);
        model_step();
        exp_q.push_back(model_out());
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input int st, input int msb, input int lsb, input int perb);
        wr_valid = 1'b1;
        wr_stage = SW'(st); wr_msb = MCW'(msb); wr_lsb = LW'(lsb); wr_perb = PW'(perb);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL cyc=%0d %s got=%h want=%h", cyc, name, got, want);
        end
    endtask

    // Monitor: the DUT presents a new output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge ref_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("glob_en", 64'(glob_en), 64'(e.glob));
                chk("inj_en", 64'(inj_en), 64'(e.inj));
                chk("busy", 64'(busy), 64'(e.busy));
                chk("locked", 64'(locked), 64'(e.locked));
                chk("wr_ready", 64'(wr_ready), 64'(e.rdy));
                chk("delay_con_lsb", 64'(delay_con_lsb), 64'(e.lsb));
                chk("delay_con_msb", 64'(delay_con_msb), 64'(e.msb));
                chk("con_perb", 64'(con_perb), 64'(e.perb));
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(3);
        // Start-up: inject window then run
        start = 1'b1;
        ticks(19);
        // Full slew of stage 2: 4 -> 7, LSB 3
        do_write(2, 7, 3, 5);
        ticks(15);
        // Slew of stage 1 aborted after the second step
        do_write(1, 7, 1, 0);
        ticks(9);
        start = 1'b0;
        ticks(2);
        // OFF writes: clamp and out-of-range stage
        do_write(0, 12, 9, 3);
        do_write(7, 2, 4, 6);
        ticks(2);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) start = ~start;
            wr_valid = ($urandom_range(0, 4) == 0);
            wr_stage = SW'($urandom_range(0, (1 << SW) - 1));
            wr_msb   = MCW'($urandom_range(0, (1 << MCW) - 1));
            wr_lsb   = LW'($urandom);
            wr_perb  = PW'($urandom);
            tick();
        end
        rst = 1'b0; wr_valid = 1'b0;
        ticks(2);
        @(negedge ref_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
